qbus_slave_sync: RTL and testbench
==================================

Name: qbus_slave_sync

Overview:
- Slave-side QBUS cycle engine between the qdrv level-converter/driver stage and the internal I/O bus that feeds the sreg_block register files.
- Synchronises the received control strobes (RSYNC/RDIN/RDOUT/RINIT) to qclk and latches I/O-page addresses.
- Runs DATI, DATO(B) and DATIO cycles against the internal bus.
- Drives TRPLY plus the Am2908 DAL controls (DALst, DALtx) and read data onto ZDAL.

Parameters:
- SYNC_STAGES, 2: flop depth of the RSYNC/RDIN/RDOUT/RINIT synchronisers (min 2).
- RPLY_SETUP, 2: qclk cycles between DALtx assertion and TRPLY assertion on reads (data setup).

Ports:
- qclk  in  1  20 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- ZDAL  inout  22  DAL from/to Am2908s; block drives only while DALst|DALtx, else Z.
- ZBS7  in  1  received BS7, asserted-high.
- ZWTBT  in  1  received WTBT, asserted-high.
- RSYNC, RDIN, RDOUT, RINIT  in  1 each  received strobes, asserted-high, asynchronous to qclk.
- TRPLY  out  1  drive BRPLY.
- DALst  out  1  strobe read data into the Am2908 output latches.
- DALtx  out  1  enable Am2908 transmit onto BDAL.
- iADDR  out  13  latched I/O-page address (byte address).
- iBS7  out  1  latched BS7, valid for the whole cycle.
- iREAD_MATCH  in  1  some register claims iADDR for read (combinational).
- iWRITE_MATCH  in  1  some register claims iADDR for write.
- iRDATA  in  16  read data for iADDR (combinational).
- iWDATA  out  16  write data.
- iWRITE  out  1  one-cycle write strobe.
- iBYTE  out  1  write is a byte write (DATOB); iADDR[0] selects the byte.

Behaviour:
- Interface: one clock, qclk; reset is synchronous and active-high. No other reset path.
- Reset: all outputs 0, iADDR/iWDATA = 0, ZDAL = Z, state IDLE.
- Synchronisers: sRSYNC/sRDIN/sRDOUT/sRINIT are SYNC_STAGES flops deep. Stage 1 of RSYNC also registers ZDAL[21:0], ZBS7 and ZWTBT in the same edge.
- Address capture: at the edge where stage-1 RSYNC goes 0→1, the registered ZDAL[12:0] → iADDR and ZBS7 → iBS7.
- States:
  - IDLE: on the sRSYNC rising edge, go to DATA if iBS7=1, else IGNORE. Memory-space cycles are never answered.
  - IGNORE: wait for sRSYNC=0, then IDLE. Outputs stay 0.
  - DATA: wait for data strobe.
    - sRDIN=1 (priority over sRDOUT): if iREAD_MATCH, latch iRDATA and go to RLOAD; else go to NXM.
    - sRDOUT=1: if iWRITE_MATCH, go to WSTB; else go to NXM.
    - sRSYNC=0: go to IDLE.
  - RLOAD: DALst=1 for one cycle. ZDAL = {6'b0, latched data}. Next state RSETUP.
  - RSETUP: DALtx=1; count RPLY_SETUP cycles, then RREPLY.
  - RREPLY: DALtx=1, TRPLY=1 until sRDIN=0; then both drop on the same edge and go to DONE.
  - WSTB: iWDATA ← ZDAL[15:0] sampled at the edge sRDOUT was first seen; iBYTE ← ZWTBT sampled the same way. iWRITE=1 for exactly one cycle. Next state WREPLY.
  - WREPLY: TRPLY=1 until sRDOUT=0, then DONE.
  - NXM: no TRPLY, ever. Wait for sRDIN=0 and sRDOUT=0, then DONE. The master times out.
  - DONE: if sRSYNC=0, go to IDLE. Else, once sRDIN=0 and sRDOUT=0, go to DATA; this second strobe in one SYNC is DATIO. iADDR is unchanged for the second transfer.
- Latency, N = first cycle the synchronised strobe is seen:
  - Read: DALst at N+1, DALtx from N+2, TRPLY at N+2+RPLY_SETUP.
  - Write: iWRITE at N+1, TRPLY from N+2.
- sRSYNC negating in any non-IDLE state returns to IDLE next cycle, with all outputs 0 and ZDAL = Z.
- sRINIT=1: same effect as reset on state and outputs while asserted.
- Post-reset partial cycle: if sRSYNC=1 on the first cycle out of reset/INIT, enter IGNORE; partial cycles are never answered.
- iWRITE never asserts on a read, an NXM, or a non-BS7 cycle.

Test Plan:
1. reset 4 cycles, then bus idle → TRPLY=DALst=DALtx=iWRITE=0, ZDAL=Z, iADDR=0.
2. DATI to 777570 (BS7=1), register matching iADDR=17570 returns 177777 → one DALst pulse, TRPLY 2 cycles after DALtx rises, ZDAL[15:0]=177777 until DIN negates; TRPLY and DALtx fall together.
3. DATI to 17400 with iREAD_MATCH=0 → TRPLY never asserts, DALst=DALtx=0 throughout; after SYNC negates, the next cycle answers normally. Also: DATI to 17570 with BS7=0 → same silence, iBS7=0.
4. DATO to 17440 data 054321, WTBT=1 at address and 0 at data → exactly one iWRITE pulse, iWDATA=054321, iBYTE=0, TRPLY asserted until DOUT negates. DATOB with WTBT=1 at data, address 17441 → iBYTE=1, iADDR[0]=1.
5. DATIO to 17560: read returns 123456; DIN drops, then DOUT with 054545 → read reply, then one iWRITE with iWDATA=054545; iADDR stays 17560 across both transfers.
6. Assert RINIT mid-read (during RSETUP) while SYNC stays asserted → outputs 0 within SYNC_STAGES+1 cycles; block stays in IGNORE until SYNC negates; no iWRITE issued.

Source files
------------

// File: rtl/qbus_slave_sync.sv
// QBUS slave cycle engine: synchronises the received bus strobes, latches I/O-page
// addresses and runs DATI/DATO(B)/DATIO transfers against the internal register bus.
module qbus_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RPLY_SETUP  = 2
) (
  input  logic        qclk,
  input  logic        reset,
  inout  wire  [21:0] ZDAL,
  input  logic        ZBS7,
  input  logic        ZWTBT,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RINIT,
  output logic        TRPLY,
  output logic        DALst,
  output logic        DALtx,
  output logic [12:0] iADDR,
  output logic        iBS7,
  input  logic        iREAD_MATCH,
  input  logic        iWRITE_MATCH,
  input  logic [15:0] iRDATA,
  output logic [15:0] iWDATA,
  output logic        iWRITE,
  output logic        iBYTE
);

  localparam int unsigned CNT_W = (RPLY_SETUP > 1) ? $clog2(RPLY_SETUP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_IGNORE, S_DATA, S_RLOAD, S_RSETUP,
    S_RREPLY, S_WSTB, S_WREPLY, S_NXM, S_DONE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync_sh;
  logic [SYNC_STAGES-1:0] r_din_sh;
  logic [SYNC_STAGES-1:0] r_dout_sh;
  logic [SYNC_STAGES-1:0] r_init_sh;
  logic [21:0]            r_dal1;
  logic                   r_bs71;
  logic                   r_wtbt1;
  logic                   r_srsync_d;
  logic [15:0]            r_rdata;
  logic [CNT_W-1:0]       r_cnt;

  logic w_srsync;
  logic w_srdin;
  logic w_srdout;
  logic w_srinit;
  logic w_s1_rise;
  logic w_srsync_rise;
  logic w_unused_dal;

  assign w_srsync      = r_sync_sh[SYNC_STAGES-1];
  assign w_srdin       = r_din_sh[SYNC_STAGES-1];
  assign w_srdout      = r_dout_sh[SYNC_STAGES-1];
  assign w_srinit      = r_init_sh[SYNC_STAGES-1];
  assign w_s1_rise     = r_sync_sh[0] & ~r_sync_sh[1];
  // r_srsync_d is forced high by reset/INIT so a SYNC already in flight never looks like a new cycle
  assign w_srsync_rise = w_srsync & ~r_srsync_d;
  assign w_unused_dal  = ^r_dal1[21:16];

  assign ZDAL = (DALst | DALtx) ? {6'b0, r_rdata} : {22{1'bz}};

  // Strobe synchronisers; DAL/BS7/WTBT are captured alongside SYNC stage 1
  always_ff @(posedge qclk) begin
    r_sync_sh <= {r_sync_sh[SYNC_STAGES-2:0], RSYNC};
    r_din_sh  <= {r_din_sh[SYNC_STAGES-2:0], RDIN};
    r_dout_sh <= {r_dout_sh[SYNC_STAGES-2:0], RDOUT};
    r_init_sh <= {r_init_sh[SYNC_STAGES-2:0], RINIT};
    r_dal1    <= ZDAL;
    r_bs71    <= ZBS7;
    r_wtbt1   <= ZWTBT;
  end

  // Cycle FSM with registered outputs
  always_ff @(posedge qclk) begin
    if (reset || w_srinit) begin
      r_state    <= S_IDLE;
      r_srsync_d <= 1'b1;
      r_rdata    <= '0;
      r_cnt      <= '0;
      TRPLY      <= 1'b0;
      DALst      <= 1'b0;
      DALtx      <= 1'b0;
      iADDR      <= '0;
      iBS7       <= 1'b0;
      iWDATA     <= '0;
      iWRITE     <= 1'b0;
      iBYTE      <= 1'b0;
    end else begin
      r_srsync_d <= w_srsync;
      DALst      <= 1'b0;
      iWRITE     <= 1'b0;
      if (w_s1_rise) begin
        iADDR <= r_dal1[12:0];
        iBS7  <= r_bs71;
      end

      if (r_state != S_IDLE && !w_srsync) begin
        r_state <= S_IDLE;
        TRPLY   <= 1'b0;
        DALtx   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_srsync)
              r_state <= (w_srsync_rise && iBS7) ? S_DATA : S_IGNORE;
          end
          S_IGNORE: r_state <= S_IGNORE;
          S_DATA: begin
            if (w_srdin) begin
              if (iREAD_MATCH) begin
                r_rdata <= iRDATA;
                DALst   <= 1'b1;
                r_state <= S_RLOAD;
              end else begin
                r_state <= S_NXM;
              end
            end else if (w_srdout) begin
              if (iWRITE_MATCH) begin
                iWDATA  <= r_dal1[15:0];
                iBYTE   <= r_wtbt1;
                iWRITE  <= 1'b1;
                r_state <= S_WSTB;
              end else begin
                r_state <= S_NXM;
              end
            end
          end
          S_RLOAD: begin
            DALtx   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RSETUP;
          end
          S_RSETUP: begin
            if (r_cnt == CNT_W'(RPLY_SETUP - 1)) begin
              TRPLY   <= 1'b1;
              r_state <= S_RREPLY;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_RREPLY: begin
            if (!w_srdin) begin
              TRPLY   <= 1'b0;
              DALtx   <= 1'b0;
              r_state <= S_DONE;
            end
          end
          S_WSTB: begin
            TRPLY   <= 1'b1;
            r_state <= S_WREPLY;
          end
          S_WREPLY: begin
            if (!w_srdout) begin
              TRPLY   <= 1'b0;
              r_state <= S_DONE;
            end
          end
          S_NXM: begin
            if (!w_srdin && !w_srdout) r_state <= S_DONE;
          end
          S_DONE: begin
            // strobes idle with SYNC still held: a second transfer (DATIO) may follow
            if (!w_srdin && !w_srdout) r_state <= S_DATA;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qbus_slave_sync.sv
// Self-checking bench for qbus_slave_sync: table of bus cycles plus DATIO and INIT sequences,
// with read/write scoreboards fed by the bus master model.
module tb_qbus_slave_sync;

  localparam int S = 2;
  localparam int R = 2;

  logic        qclk = 1'b0;
  logic        reset;
  wire  [21:0] ZDAL;
  logic        ZBS7, ZWTBT, RSYNC, RDIN, RDOUT, RINIT;
  logic        TRPLY, DALst, DALtx, iBS7, iWRITE, iBYTE;
  logic [12:0] iADDR;
  logic [15:0] iWDATA, iRDATA;
  logic        iREAD_MATCH, iWRITE_MATCH;

  logic [21:0] m_dal;
  logic        m_oe;
  assign ZDAL = m_oe ? m_dal : {22{1'bz}};

  // register-file model
  logic [12:0] tb_rd_addr, tb_wr_addr;
  logic [15:0] tb_rd_val;
  logic        tb_rd_en, tb_wr_en;
  assign iREAD_MATCH  = tb_rd_en && (iADDR == tb_rd_addr);
  assign iRDATA       = iREAD_MATCH ? tb_rd_val : 16'o0;
  assign iWRITE_MATCH = tb_wr_en && (iADDR[12:1] == tb_wr_addr[12:1]);

  qbus_slave_sync #(.SYNC_STAGES(S), .RPLY_SETUP(R)) dut (
    .qclk(qclk), .reset(reset), .ZDAL(ZDAL), .ZBS7(ZBS7), .ZWTBT(ZWTBT),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RINIT(RINIT),
    .TRPLY(TRPLY), .DALst(DALst), .DALtx(DALtx), .iADDR(iADDR), .iBS7(iBS7),
    .iREAD_MATCH(iREAD_MATCH), .iWRITE_MATCH(iWRITE_MATCH), .iRDATA(iRDATA),
    .iWDATA(iWDATA), .iWRITE(iWRITE), .iBYTE(iBYTE)
  );

  always #25 qclk = ~qclk;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
    logic        byt;
  } wr_t;

  typedef struct packed {
    logic        is_write;
    logic [12:0] addr;
    logic        bs7;
    logic        match;
    logic [15:0] data;
    logic        wtbt_a;
    logic        wtbt_d;
    logic        exp_reply;
    logic        exp_write;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  logic        trply_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard consumers: write strobes and read-reply data
  always @(negedge qclk) begin
    wr_t e;
    logic [15:0] d;
    if (iWRITE) begin
      wr_count++;
      if (wr_q.size() == 0) begin
        check("unexpected_iwrite", 32'(iADDR), 32'h7fffffff);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(iADDR), 32'(e.addr));
        check("wr_data", 32'(iWDATA), 32'(e.data));
        check("wr_byte", 32'(iBYTE), 32'(e.byt));
      end
    end
    if (TRPLY && !trply_d && DALtx) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read_reply", 32'(ZDAL), 32'h7fffffff);
      end else begin
        d = rd_q.pop_front();
        check("rd_zdal", 32'(ZDAL), 32'({6'b0, d}));
      end
    end
    trply_d = TRPLY;
  end

  task automatic addr_phase(input logic [12:0] a, input logic bs7, input logic wtbt);
    m_dal = 22'(a); m_oe = 1'b1; ZBS7 = bs7; ZWTBT = wtbt;
    @(negedge qclk);
    RSYNC = 1'b1;
    repeat (S + 3) @(negedge qclk);
  endtask

  task automatic wait_trply(input logic lvl, output int k);
    k = 0;
    for (int i = 1; i <= 16 && k == 0; i++) begin
      @(negedge qclk);
      if (TRPLY == lvl) k = i;
    end
  endtask

  task automatic end_cycle(input string p);
    RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; m_oe = 1'b0; ZBS7 = 1'b0; ZWTBT = 1'b0;
    repeat (S + 3) @(negedge qclk);
    check({p, "_idle_outs"}, 32'({TRPLY, DALst, DALtx, iWRITE}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string p);
    int k_st, k_tx, k_rp, n_st, k_rp_off, k_tx_off, w0;
    tb_rd_addr = v.addr; tb_rd_val = v.data; tb_rd_en = !v.is_write && v.match;
    tb_wr_addr = v.addr; tb_wr_en = v.is_write && v.match;
    addr_phase(v.addr, v.bs7, v.wtbt_a);
    check({p, "_iaddr"}, 32'(iADDR), 32'(v.addr));
    check({p, "_ibs7"}, 32'(iBS7), 32'(v.bs7));
    ZBS7 = 1'b0; ZWTBT = v.wtbt_d;
    if (v.is_write) m_dal = 22'(v.data); else m_oe = 1'b0;
    @(negedge qclk);
    w0 = wr_count;
    if (v.exp_write) wr_q.push_back('{addr: v.addr, data: v.data, byt: v.wtbt_d});
    if (v.exp_reply && !v.is_write) rd_q.push_back(v.data);
    if (v.is_write) RDOUT = 1'b1; else RDIN = 1'b1;
    k_st = 0; k_tx = 0; k_rp = 0; n_st = 0;
    for (int k = 1; k <= 16 && k_rp == 0; k++) begin
      @(negedge qclk);
      if (DALst) begin n_st++; if (k_st == 0) k_st = k; end
      if (DALtx && k_tx == 0) k_tx = k;
      if (TRPLY) k_rp = k;
    end
    if (v.is_write) begin
      check({p, "_trply_lat"}, 32'(k_rp), v.exp_reply ? 32'(S + 2) : 32'd0);
      check({p, "_dal_quiet"}, 32'(k_st + k_tx), 32'd0);
    end else begin
      check({p, "_trply_lat"}, 32'(k_rp), v.exp_reply ? 32'(S + 2 + R) : 32'd0);
      check({p, "_dalst_lat"}, 32'(k_st), v.exp_reply ? 32'(S + 1) : 32'd0);
      check({p, "_dalst_cnt"}, 32'(n_st), v.exp_reply ? 32'd1 : 32'd0);
      check({p, "_daltx_lat"}, 32'(k_tx), v.exp_reply ? 32'(S + 2) : 32'd0);
    end
    RDIN = 1'b0; RDOUT = 1'b0;
    k_rp_off = 0; k_tx_off = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge qclk);
      if (!TRPLY && k_rp_off == 0) k_rp_off = k;
      if (!DALtx && k_tx_off == 0) k_tx_off = k;
    end
    if (v.exp_reply) check({p, "_trply_off"}, 32'(k_rp_off), 32'(S + 1));
    if (v.exp_reply && !v.is_write) check({p, "_daltx_off"}, 32'(k_tx_off), 32'(k_rp_off));
    check({p, "_wr_pulses"}, 32'(wr_count - w0), v.exp_write ? 32'd1 : 32'd0);
    end_cycle(p);
  endtask

  vec_t vecs[7];

  initial begin
    int k, w0, act;
    //              wr    addr      bs7  m    data        wa   wd   rply wr
    vecs[0] = '{1'b0, 13'o17570, 1'b1, 1'b1, 16'o177777, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 13'o17400, 1'b1, 1'b0, 16'o000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 13'o17570, 1'b1, 1'b1, 16'o012345, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 13'o17570, 1'b0, 1'b1, 16'o177777, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 13'o17440, 1'b1, 1'b1, 16'o054321, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 13'o17441, 1'b1, 1'b1, 16'o000252, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 13'o17400, 1'b1, 1'b0, 16'o070707, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RINIT = 1'b0;
    ZBS7 = 1'b0; ZWTBT = 1'b0; m_dal = '0; m_oe = 1'b0;
    tb_rd_addr = '0; tb_wr_addr = '0; tb_rd_val = '0; tb_rd_en = 1'b0; tb_wr_en = 1'b0;
    repeat (4) @(negedge qclk);
    reset = 1'b0;
    repeat (3) @(negedge qclk);
    check("reset_outs", 32'({TRPLY, DALst, DALtx, iWRITE}), 32'd0);
    check("reset_iaddr", 32'(iADDR), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // DATIO: read then write within one SYNC
    tb_rd_addr = 13'o17560; tb_rd_val = 16'o123456; tb_rd_en = 1'b1;
    tb_wr_addr = 13'o17560; tb_wr_en = 1'b1;
    addr_phase(13'o17560, 1'b1, 1'b0);
    ZBS7 = 1'b0; m_oe = 1'b0;
    @(negedge qclk);
    rd_q.push_back(16'o123456);
    RDIN = 1'b1;
    wait_trply(1'b1, k);
    check("datio_rd_reply", 32'(k), 32'(S + 2 + R));
    RDIN = 1'b0;
    wait_trply(1'b0, k);
    check("datio_rd_release", 32'(k != 0), 32'd1);
    m_dal = 22'o054545; m_oe = 1'b1; ZWTBT = 1'b0;
    @(negedge qclk);
    w0 = wr_count;
    wr_q.push_back('{addr: 13'o17560, data: 16'o054545, byt: 1'b0});
    RDOUT = 1'b1;
    wait_trply(1'b1, k);
    check("datio_wr_reply", 32'(k), 32'(S + 2));
    check("datio_iaddr", 32'(iADDR), 32'o17560);
    RDOUT = 1'b0;
    wait_trply(1'b0, k);
    check("datio_wr_pulses", 32'(wr_count - w0), 32'd1);
    end_cycle("datio");

    // INIT during the read data-setup window, SYNC held throughout
    tb_rd_addr = 13'o17570; tb_rd_val = 16'o111111; tb_rd_en = 1'b1;
    tb_wr_addr = 13'o00000; tb_wr_en = 1'b1;
    w0 = wr_count;
    addr_phase(13'o17570, 1'b1, 1'b0);
    ZBS7 = 1'b0; m_oe = 1'b0;
    @(negedge qclk);
    RDIN = 1'b1;
    k = 0;
    for (int i = 1; i <= 16 && k == 0; i++) begin
      @(negedge qclk);
      if (DALst) k = i;
    end
    check("init_dalst_seen", 32'(k), 32'(S + 1));
    RINIT = 1'b1;
    repeat (S + 1) @(negedge qclk);
    check("init_outs_zero", 32'({TRPLY, DALst, DALtx, iWRITE}), 32'd0);
    check("init_iaddr_zero", 32'(iADDR), 32'd0);
    repeat (3) @(negedge qclk);
    RDIN = 1'b0; RINIT = 1'b0;
    repeat (S + 3) @(negedge qclk);
    act = 0;
    RDIN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge qclk);
      act += int'(TRPLY) + int'(DALst) + int'(DALtx);
    end
    RDIN = 1'b0;
    repeat (S + 2) @(negedge qclk);
    RDOUT = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge qclk);
      act += int'(TRPLY) + int'(iWRITE);
    end
    check("init_ignore_silent", 32'(act), 32'd0);
    check("init_no_write", 32'(wr_count - w0), 32'd0);
    end_cycle("init");
    run_vec(vecs[2], "post_init");

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
